// File: rtl/l2_mem_responder.sv
// L2 backing-store responder: fixed-latency word memory behind the bus
// controller's L2 port, with per-request error checks, abort and activity counters.
module l2_mem_responder #(
  parameter int          MEM_DEPTH = 1024,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 l2REN,
  input  logic                 l2WEN,
  input  logic [31:0]          l2addr,
  input  logic [31:0]          l2store,
  output logic [31:0]          l2load,
  output logic [1:0]           l2state,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LAT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  l2_state_t          state;
  logic [LAT_W-1:0]   busy_cnt;
  logic               cap_wr;
  logic [31:0]        cap_addr;
  logic [IDX_W-1:0]   cap_idx;
  logic [31:0]        cap_data;
  logic [31:0]        mem [MEM_DEPTH];

  logic [31:0]        offset;
  logic [IDX_W-1:0]   req_idx;
  logic               req_any;
  logic               req_bad;
  logic               same_type;
  logic               abort;
  logic               commit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Request decode, evaluated combinationally against the live inputs.
  always_comb begin
    offset    = l2addr - BASE_ADDR;
    req_idx   = offset[IDX_W+1:2];
    req_any   = l2REN | l2WEN;
    req_bad   = (l2REN & l2WEN)
              | (l2addr[1:0] != 2'b00)
              | (l2addr < BASE_ADDR)
              | ((offset >> 2) >= 32'(MEM_DEPTH));
    // The requester must keep presenting exactly what was captured.
    same_type = cap_wr ? (l2WEN & ~l2REN) : (l2REN & ~l2WEN);
    abort     = ~same_type | (l2addr != cap_addr);
    commit    = (state == L2_BUSY) & ~abort & (busy_cnt == LAT_W'(1));
  end

  assign l2state = state;

  // Array carries no reset; RST only suppresses an in-flight commit.
  always_ff @(posedge CLK) begin
    if (!RST && commit && cap_wr)
      mem[cap_idx] <= cap_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= L2_FREE;
      busy_cnt  <= '0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_idx   <= '0;
      cap_data  <= '0;
      l2load    <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        L2_FREE: begin
          if (req_any) begin
            if (req_bad) begin
              state     <= L2_ERROR;
              err_count <= sat_inc(err_count);
            end else begin
              state    <= L2_BUSY;
              busy_cnt <= LAT_W'(LATENCY);
              cap_wr   <= l2WEN;
              cap_addr <= l2addr;
              cap_idx  <= req_idx;
              cap_data <= l2store;
            end
          end
        end
        L2_BUSY: begin
          if (abort) begin
            state <= L2_FREE;
          end else if (commit) begin
            state <= L2_ACCESS;
            if (cap_wr) begin
              wr_count <= sat_inc(wr_count);
            end else begin
              rd_count <= sat_inc(rd_count);
              l2load   <= mem[cap_idx];
            end
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        L2_ACCESS: state <= L2_FREE;
        L2_ERROR:  state <= L2_FREE;
        default:   state <= L2_FREE;
      endcase
    end
  end

endmodule
